// File: rtl/dma_chan_sched.sv
// Round-robin scheduler that shares one APB-programmed DMA engine among NCH
// requesting channels. On a grant it latches the winner's descriptor, writes it
// into the DMA register file over an APB master port, then waits for DMA_INT
// and returns a one-cycle done (or timeout error) pulse to the granted channel.
//
// Ports:
//   PCLK, PRESETn         clock, asynchronous active-low reset
//   sched_en              arbitration enable (a running job always completes)
//   ch_req                level request per channel
//   ch_rd_addr/wr_addr/
//   ch_len/ch_step        32-bit descriptor words, channel i at [32*i +: 32]
//   ch_size               2-bit beat size per channel
//   ch_ack/done/err       one-cycle per-channel pulses
//   busy, cur_ch          status: not idle, granted channel index
//   M_PSEL..M_PWDATA      APB master write port towards the DMA
//   M_PREADY              APB ready from the DMA
//   DMA_INT               DMA completion pulse
module dma_chan_sched #(
  parameter int unsigned NCH     = 4,
  parameter int unsigned TMO_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              sched_en,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH*32-1:0] ch_rd_addr,
  input  logic [NCH*32-1:0] ch_wr_addr,
  input  logic [NCH*32-1:0] ch_len,
  input  logic [NCH*32-1:0] ch_step,
  input  logic [NCH*2-1:0]  ch_size,
  output logic [NCH-1:0]    ch_ack,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  output logic              busy,
  output logic [2:0]        cur_ch,
  output logic              M_PSEL,
  output logic              M_PWRITE,
  output logic [11:0]       M_PADDR,
  output logic [31:0]       M_PWDATA,
  input  logic              M_PREADY,
  input  logic              DMA_INT
);

  typedef enum logic [2:0] {
    StIdle, StWrRd, StWrWr, StWrLen, StWrStep, StWrCtrl, StWait, StFin
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [2:0]        ch_q, ch_d;
  logic [31:0]       rd_q, rd_d, wr_q, wr_d, len_q, len_d, step_q, step_d;
  logic [1:0]        size_q, size_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;

  // Round-robin pick: first requester at or above rr_q, else the lowest one.
  logic              found;
  logic [2:0]        gnt_idx;
  logic [2:0]        gnt_next;
  logic [31:0]       sel_rd, sel_wr, sel_len, sel_step;
  logic [1:0]        sel_size;

  always_comb begin
    found    = 1'b0;
    gnt_idx  = 3'd0;
    gnt_next = 3'd0;
    sel_rd   = '0;
    sel_wr   = '0;
    sel_len  = '0;
    sel_step = '0;
    sel_size = '0;
    for (int k = 0; k < 2 * NCH; k++) begin
      if (!found && ch_req[k % NCH] && ((k >= NCH) || (k >= int'(rr_q)))) begin
        found    = 1'b1;
        gnt_idx  = 3'(k % NCH);
        gnt_next = ((k % NCH) == NCH - 1) ? 3'd0 : 3'((k % NCH) + 1);
        sel_rd   = ch_rd_addr[32*(k%NCH) +: 32];
        sel_wr   = ch_wr_addr[32*(k%NCH) +: 32];
        sel_len  = ch_len[32*(k%NCH) +: 32];
        sel_step = ch_step[32*(k%NCH) +: 32];
        sel_size = ch_size[2*(k%NCH) +: 2];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    ch_d     = ch_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    len_d    = len_q;
    step_d   = step_q;
    size_d   = size_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    ch_ack   = '0;
    ch_done  = '0;
    ch_err   = '0;
    M_PSEL   = 1'b0;
    M_PADDR  = '0;
    M_PWDATA = '0;

    unique case (state_q)
      StIdle: begin
        if (sched_en && found) begin
          ch_ack[gnt_idx] = 1'b1;
          ch_d    = gnt_idx;
          rr_d    = gnt_next;
          rd_d    = sel_rd;
          wr_d    = sel_wr;
          len_d   = sel_len;
          step_d  = sel_step;
          size_d  = sel_size;
          state_d = StWrRd;
        end
      end
      StWrRd: begin
        M_PSEL   = 1'b1;
        M_PADDR  = 12'h000;
        M_PWDATA = rd_q;
        if (M_PREADY) state_d = StWrWr;
      end
      StWrWr: begin
        M_PSEL   = 1'b1;
        M_PADDR  = 12'h004;
        M_PWDATA = wr_q;
        if (M_PREADY) state_d = StWrLen;
      end
      StWrLen: begin
        M_PSEL   = 1'b1;
        M_PADDR  = 12'h008;
        M_PWDATA = len_q;
        if (M_PREADY) state_d = StWrStep;
      end
      StWrStep: begin
        M_PSEL   = 1'b1;
        M_PADDR  = 12'h00C;
        M_PWDATA = step_q;
        if (M_PREADY) state_d = StWrCtrl;
      end
      StWrCtrl: begin
        M_PSEL   = 1'b1;
        M_PADDR  = 12'h010;
        M_PWDATA = {26'b0, size_q, 4'b0001};
        if (M_PREADY) begin
          tmo_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        // Completion takes priority over a timeout expiring in the same cycle.
        if (DMA_INT) begin
          err_d   = 1'b0;
          state_d = StFin;
        end else if ((TIMEOUT != 0) && (tmo_q == TMO_W'(TIMEOUT - 1))) begin
          err_d   = 1'b1;
          state_d = StFin;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StFin: begin
        if (err_q) ch_err[ch_q]  = 1'b1;
        else       ch_done[ch_q] = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign M_PWRITE = M_PSEL;
  assign busy     = (state_q != StIdle);
  assign cur_ch   = busy ? ch_q : 3'd0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      rr_q    <= '0;
      ch_q    <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      len_q   <= '0;
      step_q  <= '0;
      size_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ch_q    <= ch_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      len_q   <= len_d;
      step_q  <= step_d;
      size_q  <= size_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

endmodule
